mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult and multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div and divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 A  input  32  operand from rs, or source value for mthi/mtlo.
REQ-006 B  input  32  operand from rt.
REQ-007 MDUOp  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9-15 behave as none.
REQ-008 start  input  1  E-stage pulse that issues a mult/multu/div/divu.
REQ-009 req  input  1  exception/interrupt flush in the current cycle; suppresses any issue or HI/LO write sampled in the same cycle.
REQ-010 busy  output  1  drives E_HILObusy of the stall unit.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 MDUOut  output  32  read data for mfhi/mflo.

Function
REQ-014 States: IDLE and BUSY, plus a 4-bit down-counter cnt.
- Issue condition: start=1, MDUOp in 1..4, req=0, state=IDLE.
REQ-015 On issue, at that edge: latch A, B and the op; load cnt with MULT_CYCLES or DIV_CYCLES; go to BUSY.
REQ-016 In BUSY, cnt decrements by 1 each edge.
- At the edge where cnt goes 1->0: write the result to HI/LO and return to IDLE.
- Effect: busy is high for exactly N cycles after the issue edge, and the new HI/LO values are visible in the first cycle busy=0.
REQ-017 busy = (state==BUSY) OR (issue condition true this cycle), so a HILO instruction in D stalls in the same cycle start is seen.
REQ-018 mult: {HI,LO} = signed 64-bit A*B.
- multu: {HI,LO} = unsigned 64-bit A*B.
REQ-019 div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
REQ-020 Divide by zero (B=0, div or divu): still busy for DIV_CYCLES; HI and LO unchanged at completion.
REQ-021 Signed overflow (A=0x80000000, B=0xFFFFFFFF, div): LO=0x80000000, HI=0x00000000.
REQ-022 mthi/mtlo: write A to HI/LO at the edge when MDUOp=7/8, req=0 and state=IDLE; ignored in BUSY.
REQ-023 MDUOut = HI when MDUOp=5, LO when MDUOp=6, else 0.
- Combinational from the current register value; no bypass of an in-flight result.
REQ-024 start while BUSY is ignored: no restart, no counter reload.
REQ-025 req while BUSY does not abort the operation; it completes and writes HI/LO normally.
REQ-026 start with MDUOp in {0, 5..15} has no effect.
REQ-027 Operands are sampled only at the issue edge; A/B changes during BUSY do not affect the result.

Reset
REQ-028 While reset=1, asynchronously and immediately:
- HI=0, LO=0, cnt=0, state=IDLE, busy=0 (the issue term is masked during reset), latched operands cleared.
REQ-029 Reset during BUSY discards the in-flight operation; no HI/LO write occurs after reset is released.

Verification
REQ-030 mult, A=0xFFFFFFFE, B=3, start 1 cycle -> busy high 5 cycles starting with the start cycle's edge window; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 divu, A=100, B=7 -> busy 10 cycles, then LO=14, HI=2.
- div, A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 mthi A=0x1234 -> MDUOp=5 gives MDUOut=0x1234 next cycle.
- Then div with B=0 -> after 10 cycles HI=0x1234, LO unchanged.
REQ-033 mult start with req=1 -> busy stays 0 throughout, HI/LO unchanged.
- Second start 2 cycles into a div -> ignored; div completes at the original cycle count.
REQ-034 reset asserted at cycle 3 of a mult (asynchronously, mid-cycle) -> busy, HI and LO drop to 0 immediately; stay 0 after release.
REQ-035 Random signed/unsigned operands, including 0x80000000/-1 -> HI/LO match the 64-bit model after exactly N busy cycles.

Source files
------------

// File: rtl/mdu.sv
// ============================================================================
//  Module   : mdu
//  Purpose  : Multi-cycle multiply/divide unit with the architectural HI/LO
//             registers. Issues mult/multu/div/divu, holds busy for a fixed
//             latency, then commits the result to HI/LO. Also services
//             mthi/mtlo writes and mfhi/mflo reads.
//  Ports    : clk     - clock, all state updates on the rising edge
//             reset   - asynchronous active-high reset
//             A, B    - operands (A is also the mthi/mtlo source)
//             MDUOp   - 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                       7 mthi,8 mtlo, 9-15 none
//             start   - issue pulse for mult/multu/div/divu
//             req     - flush; suppresses issue and HI/LO writes this cycle
//             busy    - stall request for HI/LO consumers
//             HI, LO  - architectural registers
//             MDUOut  - mfhi/mflo read data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [3:0]  op_q,    op_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        w_issue;
    logic        w_issue_mul;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_uquo;
    logic [31:0] w_urem;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_issue = start && !req && (state_q == S_IDLE) &&
                     (MDUOp >= c_OP_MULT) && (MDUOp <= c_OP_DIVU);
    assign w_issue_mul = (MDUOp == c_OP_MULT) || (MDUOp == c_OP_MULTU);

    // The issue term lets a HI/LO reader in decode stall in the very cycle
    // start is seen; it is masked during reset so busy drops immediately.
    assign busy = (state_q == S_BUSY) || (w_issue && !reset);

    // Signed product: low 64 bits of the product of sign-extended operands.
    assign w_prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

    // One unsigned divider serves both div and divu. Signed division runs on
    // magnitudes and re-applies signs: quotient negative when operand signs
    // differ, remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // naturally: |A| = 0x80000000, quotient 0x80000000, remainder 0.
    assign w_div_signed = (op_q == c_OP_DIV);
    assign w_num  = (w_div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign w_den  = (w_div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign w_uquo = (w_den == 32'd0) ? 32'd0 : (w_num / w_den);
    assign w_urem = (w_den == 32'd0) ? 32'd0 : (w_num % w_den);
    assign w_quo  = (w_div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - w_uquo) : w_uquo;
    assign w_rem  = (w_div_signed && a_q[31]) ? (32'd0 - w_urem) : w_urem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_issue) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = MDUOp;
                    cnt_d   = w_issue_mul ? c_MULT_CNT : c_DIV_CNT;
                    state_d = S_BUSY;
                end else if (!req && (MDUOp == c_OP_MTHI)) begin
                    hi_d = A;
                end else if (!req && (MDUOp == c_OP_MTLO)) begin
                    lo_d = A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // Commit on the edge where the counter leaves 1; a zero
                // count (degenerate parameter) also completes here.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    case (op_q)
                        c_OP_MULT:  {hi_d, lo_d} = w_prod_s;
                        c_OP_MULTU: {hi_d, lo_d} = w_prod_u;
                        c_OP_DIV, c_OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (b_q != 32'd0) begin
                                hi_d = w_rem;
                                lo_d = w_quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

    // Reads the committed registers only; an in-flight result is not bypassed.
    assign MDUOut = (MDUOp == c_OP_MFHI) ? hi_q :
                    (MDUOp == c_OP_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
//  Module   : tb_mdu
//  Purpose  : Directed self-checking bench for mdu: latency, arithmetic
//             results, HI/LO moves, flush and reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int n_tests = 0;
    int n_fail  = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .start  (start),
        .req    (req),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, count busy cycles after the issue edge, then check
    // the latency and HI/LO. Operands are scrambled during BUSY. Optionally
    // drives an extra (start, MDUOp, req) pulse at busy cycle inj_cyc.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj_cyc, input logic [3:0] inj_op, input logic inj_req);
        int cnt;
        cnt = 0;
        A = a; B = b; MDUOp = op; start = 1'b1; req = 1'b0;
        #1;
        chk({tag, "_busy_issue"}, {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
        for (int i = 0; i < 40; i++) begin
            if (i == inj_cyc) begin
                start = 1'b1; MDUOp = inj_op; req = inj_req;
            end
            #1;
            if (!busy) break;
            cnt++;
            tick();
            start = 1'b0; MDUOp = 4'd0; req = 1'b0;
        end
        chk({tag, "_cycles"}, 32'(cnt), 32'(n));
        chk({tag, "_HI"}, HI, ehi);
        chk({tag, "_LO"}, LO, elo);
    endtask

    logic [31:0] ra, rb, mhi, mlo;
    logic [3:0]  rop;
    logic [63:0] p64;
    longint      sq, sr;

    initial begin
        reset = 1'b1; A = 32'd0; B = 32'd0; MDUOp = 4'd0; start = 1'b0; req = 1'b0;
        #2;
        // Issue term must be masked while reset is high.
        start = 1'b1; MDUOp = 4'd1;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        start = 1'b0; MDUOp = 4'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        run_op("mult_neg2x3", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, -1, 4'd0, 1'b0);
        run_op("divu_100_7_req", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 3, 4'd0, 1'b1);
        run_op("div_m7_2_restart", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 2, 4'd1, 1'b0);

        MDUOp = 4'd7; A = 32'h1234;
        tick();
        MDUOp = 4'd5; A = 32'd0;
        #1;
        chk("mfhi_after_mthi", MDUOut, 32'h1234);
        MDUOp = 4'd6;
        #1;
        chk("mflo", MDUOut, 32'hFFFFFFFD);
        MDUOp = 4'd0;
        #1;
        chk("mduout_none", MDUOut, 32'd0);

        // Divide by zero, with an mthi attempted while busy (ignored).
        run_op("div_by_zero", 4'd3, 32'd55, 32'd0, 10, 32'h1234, 32'hFFFFFFFD, 4, 4'd7, 1'b0);

        // Issue suppressed by req.
        A = 32'd3; B = 32'd4; MDUOp = 4'd1; start = 1'b1; req = 1'b1;
        #1;
        chk("req_issue_busy", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0; MDUOp = 4'd0; req = 1'b0;
        #1;
        chk("req_issue_busy2", {31'd0, busy}, 32'd0);
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("req_issue_HI", HI, 32'h1234);
        chk("req_issue_LO", LO, 32'hFFFFFFFD);

        // start with a non-arithmetic code does nothing.
        MDUOp = 4'd5; start = 1'b1;
        #1;
        chk("start_mfhi_busy", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0; MDUOp = 4'd0;
        #1;
        chk("start_mfhi_busy2", {31'd0, busy}, 32'd0);

        // mtlo blocked by req, then accepted.
        MDUOp = 4'd8; A = 32'hCAFE; req = 1'b1;
        tick();
        chk("mtlo_req_LO", LO, 32'hFFFFFFFD);
        req = 1'b0;
        tick();
        MDUOp = 4'd0;
        chk("mtlo_LO", LO, 32'hCAFE);

        run_op("div_ovf",    4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, -1, 4'd0, 1'b0);
        run_op("multu_max",  4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, -1, 4'd0, 1'b0);
        run_op("mult_min",   4'd1, 32'h80000000, 32'hFFFFFFFF, 5,  32'h00000000, 32'h80000000, -1, 4'd0, 1'b0);
        run_op("div_7_m2",   4'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, -1, 4'd0, 1'b0);
        run_op("div_m7_m2",  4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003, -1, 4'd0, 1'b0);
        run_op("divu_max_2", 4'd4, 32'hFFFFFFFF, 32'd2,        10, 32'h00000001, 32'h7FFFFFFF, -1, 4'd0, 1'b0);

        // Random operands against a 64-bit reference model.
        for (int k = 0; k < 8; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 4'(1 + (k % 4));
            if (rb == 32'd0) rb = 32'd1;
            case (rop)
                4'd1: begin
                    sq = longint'($signed(ra)) * longint'($signed(rb));
                    p64 = 64'(sq);
                    {mhi, mlo} = p64;
                end
                4'd2: begin
                    p64 = {32'd0, ra} * {32'd0, rb};
                    {mhi, mlo} = p64;
                end
                4'd3: begin
                    sq = longint'($signed(ra)) / longint'($signed(rb));
                    sr = longint'($signed(ra)) % longint'($signed(rb));
                    mlo = sq[31:0];
                    mhi = sr[31:0];
                end
                default: begin
                    mlo = ra / rb;
                    mhi = ra % rb;
                end
            endcase
            run_op("random", rop, ra, rb, (rop <= 4'd2) ? 5 : 10, mhi, mlo, -1, 4'd0, 1'b0);
        end

        // Asynchronous reset in the middle of a mult.
        MDUOp = 4'd8; A = 32'hBEEF;
        tick();
        MDUOp = 4'd1; A = 32'd5; B = 32'd6; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 4'd0;
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_HI", HI, 32'd0);
        chk("async_rst_LO", LO, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_HI", HI, 32'd0);
        chk("post_rst_LO", LO, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
